// File: rtl/enum_rr_sched_pkg.sv
// Shared types and constants for the enum_rr_sched round-robin scheduler.
// Grant codes and FSM states are int-based enums with explicit values.
package enum_rr_sched_pkg;

  localparam int N_REQ = 4;
  localparam int PTR_W = 2;

  typedef enum int {
    GNT_NONE = 0,
    GNT_A    = 1,
    GNT_B    = 2,
    GNT_C    = 3,
    GNT_D    = 4
  } grant_e;

  // No state uses encoding 0, so a zeroed register is never a legal state.
  typedef enum int {
    ST_IDLE  = 1,
    ST_GRANT = 2,
    ST_DRAIN = 3
  } sched_state_e;

  // Requester index 0..3 maps onto grant codes A..D.
  function automatic grant_e idx_to_grant(input logic [PTR_W-1:0] idx);
    return grant_e'(int'(idx) + 1);
  endfunction

  // Inverse of idx_to_grant; only meaningful for non-NONE codes.
  function automatic logic [PTR_W-1:0] grant_to_idx(input grant_e g);
    return PTR_W'(int'(g) - 1);
  endfunction

endpackage

// File: rtl/enum_rr_pick.sv
// Combinational round-robin picker: searches requesters starting one past
// the last granted index, wrapping D -> A. Returns NONE when nothing requests.
module enum_rr_pick
  import enum_rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] last,
  output grant_e           winner
);

  logic [PTR_W-1:0] cand [N_REQ];
  logic             hit  [N_REQ];

  // Candidate for search offset gi+1; offset N_REQ wraps back to 'last'.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand[gi] = last + PTR_W'(gi + 1);
      assign hit[gi]  = req_i[cand[gi]];
    end
  endgenerate

  // Lowest search offset with an active request wins.
  always_comb begin
    winner = GNT_NONE;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        winner = idx_to_grant(cand[i]);
      end
    end
  end

endmodule

// File: rtl/enum_rr_sched.sv
// Four-requester round-robin scheduler with IDLE/GRANT/DRAIN FSM.
// Optional hold timeout compiled in with `define ENUM_RR_SCHED_TIMEOUT_EN;
// without it timeout_o is tied low and grants are held until done/abandon.
module enum_rr_sched
  import enum_rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output grant_e           grant_o,
  output logic             grant_vld_o,
  output sched_state_e     state_o,
  output logic             timeout_o
);

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("enum_rr_sched: MAX_HOLD must be in 2..255");
    end
  endgenerate

  sched_state_e     state_reg, state_next;
  grant_e           grant_reg, grant_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  grant_e           winner;
  logic             holder_req;
  logic             release_req;

  enum_rr_pick u_pick (
    .req_i  (req_i),
    .last   (ptr_reg),
    .winner (winner)
  );

  // While in GRANT the pointer names the holder, so its request bit is here.
  assign holder_req  = req_i[ptr_reg];
  assign release_req = done_i || !holder_req;

`ifdef ENUM_RR_SCHED_TIMEOUT_EN
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic       timeout_reg, timeout_next;
  logic       hold_expired;

  assign hold_expired = (hold_cnt_reg == 8'(MAX_HOLD - 1));
`endif

  // Next-state and next-output logic; release (done or abandon) wins over timeout.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
`ifdef ENUM_RR_SCHED_TIMEOUT_EN
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (winner != GNT_NONE) begin
          state_next = ST_GRANT;
          grant_next = winner;
          ptr_next   = grant_to_idx(winner);
`ifdef ENUM_RR_SCHED_TIMEOUT_EN
          hold_cnt_next = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_req) begin
          state_next = ST_DRAIN;
          grant_next = GNT_NONE;
        end
`ifdef ENUM_RR_SCHED_TIMEOUT_EN
        else if (hold_expired) begin
          state_next   = ST_DRAIN;
          grant_next   = GNT_NONE;
          timeout_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
`endif
      end
      ST_DRAIN: begin
        state_next = ST_IDLE;
        grant_next = GNT_NONE;
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = GNT_NONE;
      end
    endcase
  end

  // State register; pointer resets to D so A is searched first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      grant_reg <= GNT_NONE;
      ptr_reg   <= PTR_W'(N_REQ - 1);
`ifdef ENUM_RR_SCHED_TIMEOUT_EN
      hold_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
`ifdef ENUM_RR_SCHED_TIMEOUT_EN
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
`endif
    end
  end

  assign grant_o     = grant_reg;
  assign grant_vld_o = (grant_reg != GNT_NONE);
  assign state_o     = state_reg;
`ifdef ENUM_RR_SCHED_TIMEOUT_EN
  assign timeout_o = timeout_reg;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_enum_rr_sched.sv
// Self-checking bench for enum_rr_sched: directed vector table, multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_enum_rr_sched;
  import enum_rr_sched_pkg::*;

`ifdef ENUM_RR_SCHED_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
  localparam bit TO_EN       = 1'b1;
`else
  localparam int TB_MAX_HOLD = 16;
  localparam bit TO_EN       = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req   = 4'd0;
  logic         done  = 1'b0;
  grant_e       grant;
  logic         grant_vld;
  sched_state_e state;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  enum_rr_sched #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .done_i      (done),
    .grant_o     (grant),
    .grant_vld_o (grant_vld),
    .state_o     (state),
    .timeout_o   (timeout)
  );

  // Behavioural model: state 1/2/3, grant code 0..4, last index 0..3.
  int m_state = 1, m_grant = 0, m_last = 3, m_cnt = 0;
  int m_to = 0;

  task automatic model_step(input bit r, input logic [3:0] q, input bit d);
    int pick;
    pick = -1;
    if (!r) begin
      m_state = 1; m_grant = 0; m_last = 3; m_cnt = 0; m_to = 0;
    end else if (m_state == 1) begin
      m_to = 0;
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && q[(m_last + k) % 4]) pick = (m_last + k) % 4;
      if (pick >= 0) begin
        m_state = 2; m_grant = pick + 1; m_last = pick; m_cnt = 0;
      end
    end else if (m_state == 2) begin
      m_to = 0;
      if (d || !q[m_last]) begin
        m_state = 3; m_grant = 0;
      end else if (TO_EN && m_cnt == TB_MAX_HOLD - 1) begin
        m_state = 3; m_grant = 0; m_to = 1;
      end else begin
        m_cnt++;
      end
    end else begin
      m_state = 1; m_grant = 0; m_to = 0;
    end
  endtask

  task automatic apply(input bit r, input logic [3:0] q, input bit d);
    rst_n = r; req = q; done = d;
    model_step(r, q, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int eg, input int es, input int et);
    check_val({tag, ".grant"}, int'(grant), eg);
    check_val({tag, ".vld"}, int'(grant_vld), int'(eg != 0));
    check_val({tag, ".state"}, int'(state), es);
    check_val({tag, ".timeout"}, int'(timeout), et);
  endtask

  typedef struct {
    bit         r;
    logic [3:0] q;
    bit         d;
    int         eg;
    int         es;
    int         et;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [3:0] rq;
    bit         rr, rd;
    int         exp_seq[5];
    exp_seq = '{1, 2, 3, 4, 1};

    // Reset, single requester A held, done in the fifth cycle.
    tbl.push_back('{0, 4'b0000, 0, 0, 1, 0});
    tbl.push_back('{1, 4'b0001, 0, 1, 2, 0});
    tbl.push_back('{1, 4'b0001, 0, 1, 2, 0});
    tbl.push_back('{1, 4'b0001, 0, 1, 2, 0});
    tbl.push_back('{1, 4'b0001, 0, 1, 2, 0});
    tbl.push_back('{1, 4'b0001, 1, 0, 3, 0});
    tbl.push_back('{1, 4'b0000, 0, 0, 1, 0});
    // done in IDLE ignored
    tbl.push_back('{1, 4'b0000, 1, 0, 1, 0});
    // Grant B, then A and B request: wrap search C, D, A picks A.
    tbl.push_back('{1, 4'b0010, 0, 2, 2, 0});
    tbl.push_back('{1, 4'b0010, 1, 0, 3, 0});
    tbl.push_back('{1, 4'b0011, 0, 0, 1, 0});
    tbl.push_back('{1, 4'b0011, 0, 1, 2, 0});
    tbl.push_back('{1, 4'b0011, 1, 0, 3, 0});
    tbl.push_back('{1, 4'b0100, 1, 0, 1, 0});
    // Grant C, then abandon without done.
    tbl.push_back('{1, 4'b0100, 0, 3, 2, 0});
    tbl.push_back('{1, 4'b0000, 0, 0, 3, 0});
    tbl.push_back('{1, 4'b0000, 0, 0, 1, 0});
    // Grant D, reset mid-grant, next grant A.
    tbl.push_back('{1, 4'b1000, 0, 4, 2, 0});
    tbl.push_back('{0, 4'b1000, 0, 0, 1, 0});
    tbl.push_back('{1, 4'b1001, 0, 1, 2, 0});

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].q, tbl[i].d);
      $display("vec %0d: rst_n=%0b req=%b done=%0b -> grant=%0d state=%0d timeout=%0b",
               i, tbl[i].r, tbl[i].q, tbl[i].d, int'(grant), int'(state), timeout);
      check_all($sformatf("vec%0d", i), tbl[i].eg, tbl[i].es, tbl[i].et);
    end

    // All four requesting, done on every third GRANT cycle.
    apply(0, 4'b0000, 0);
    check_all("rr.reset", 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      apply(1, 4'b1111, 0);
      check_all($sformatf("rr%0d.g1", k), exp_seq[k], 2, 0);
      apply(1, 4'b1111, 0);
      check_all($sformatf("rr%0d.g2", k), exp_seq[k], 2, 0);
      apply(1, 4'b1111, 0);
      check_all($sformatf("rr%0d.g3", k), exp_seq[k], 2, 0);
      apply(1, 4'b1111, 1);
      check_all($sformatf("rr%0d.drain", k), 0, 3, 0);
      apply(1, 4'b1111, 0);
      check_all($sformatf("rr%0d.idle", k), 0, 1, 0);
      $display("rr grant %0d: code %0d", k, exp_seq[k]);
    end

    // Long hold without done: timeout in the compiled-in variant, else held.
    apply(0, 4'b0000, 0);
    apply(1, 4'b0001, 0);
    check_all("hold.first", 1, 2, 0);
    if (TO_EN) begin
      for (int c = 1; c < TB_MAX_HOLD; c++) begin
        apply(1, 4'b0001, 0);
        check_all($sformatf("hold.c%0d", c), 1, 2, 0);
      end
      apply(1, 4'b0001, 0);
      check_all("hold.timeout", 0, 3, 1);
      apply(1, 4'b0001, 0);
      check_all("hold.after", 0, 1, 0);
      $display("hold: timeout after %0d grant cycles", TB_MAX_HOLD);
    end else begin
      for (int c = 1; c < 100; c++) begin
        apply(1, 4'b0001, 0);
        check_all($sformatf("hold.c%0d", c), 1, 2, 0);
      end
      $display("hold: grant held for 100 cycles");
    end

    // Randomized traffic against the model.
    apply(0, 4'b0000, 0);
    rq = 4'd0;
    for (int n = 0; n < 600; n++) begin
      rr = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 2) == 0) rq = 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 4) == 0);
      apply(rr, rq, rd);
      check_all($sformatf("rand%0d", n), m_grant, m_state, m_to);
    end
    $display("random: 600 cycles compared against model");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
